// File: rtl/mic_pkg.sv
// mic_pkg: shared types and constants for the microphone frequency/BCD path
package mic_pkg;
    typedef enum logic [1:0] {IDLE, MEASURE, LATCH} state_t;
    localparam int CLK_HZ          = 100000000;
    localparam int HZ_W            = 10;
    localparam int HOLDOFF_DEFAULT = 50000;
    localparam int BCD_W           = 4;
endpackage

// File: rtl/mic_edge_qualifier.sv
// mic_edge_qualifier: synchronizes mic_in, detects rising edges and rejects chatter with a holdoff
module mic_edge_qualifier
    import mic_pkg::*;
#(
    parameter int HOLDOFF_CYCLES = HOLDOFF_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mic_in,
    output logic accept
);
    localparam int HW = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYCLES);
    logic [2:0]    sync_q, sync_d;
    logic [HW-1:0] hold_q, hold_d;
    always_comb begin
        sync_d = {sync_q[1:0], mic_in};
        accept = sync_q[1] & ~sync_q[2] & (hold_q == '0);
        hold_d = accept ? HOLD_LOAD : ((hold_q != '0) ? hold_q - HW'(1) : hold_q);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hold_q <= '0;
        end else begin
            sync_q <= sync_d;
            hold_q <= hold_d;
        end
    end
endmodule

// File: rtl/mic_hz_counter.sv
// mic_hz_counter: counts qualified mic edges per gate window and latches a saturated Hz value
module mic_hz_counter
    import mic_pkg::*;
#(
    parameter int GATE_CYCLES    = CLK_HZ,
    parameter int HOLDOFF_CYCLES = HOLDOFF_DEFAULT,
    parameter int HZ_MAX         = 1023
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mic_in,
    input  logic            enable,
    output logic [HZ_W-1:0] Hz,
    output logic            hz_valid,
    output logic            overflow
);
    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int EW = HZ_W + 1;
    localparam logic [GW-1:0]   GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [EW-1:0]   EDGE_SAT  = EW'(HZ_MAX + 1);
    localparam logic [EW-1:0]   EDGE_MAX  = EW'(HZ_MAX);
    localparam logic [HZ_W-1:0] HZ_CLAMP  = HZ_W'(HZ_MAX);
    state_t          state_q, state_d;
    logic [GW-1:0]   gate_q, gate_d;
    logic [EW-1:0]   edge_q, edge_d;
    logic [HZ_W-1:0] hz_q, hz_d;
    logic            valid_q, valid_d;
    logic            ovf_q, ovf_d;
    logic            accept;
    mic_edge_qualifier #(.HOLDOFF_CYCLES(HOLDOFF_CYCLES)) u_qual (
        .clk    (clk),
        .rst_n  (rst_n),
        .mic_in (mic_in),
        .accept (accept)
    );
    always_comb begin
        state_d = state_q;
        gate_d  = gate_q + GW'(1);
        edge_d  = (accept && edge_q != EDGE_SAT) ? edge_q + EW'(1) : edge_q;
        hz_d    = hz_q;
        valid_d = 1'b0;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                gate_d  = '0;
                edge_d  = '0;
                state_d = enable ? MEASURE : IDLE;
            end
            MEASURE: begin
                if (!enable) begin
                    state_d = IDLE;
                    gate_d  = '0;
                    edge_d  = '0;
                end else if (gate_q == GATE_LAST) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                hz_d    = (edge_q > EDGE_MAX) ? HZ_CLAMP : edge_q[HZ_W-1:0];
                ovf_d   = edge_q > EDGE_MAX;
                valid_d = 1'b1;
                gate_d  = '0;
                // an edge accepted while latching opens the next window's count
                edge_d  = {{(EW-1){1'b0}}, accept};
                state_d = enable ? MEASURE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gate_q  <= '0;
            edge_q  <= '0;
            hz_q    <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
            edge_q  <= edge_d;
            hz_q    <= hz_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end
    assign Hz       = hz_q;
    assign hz_valid = valid_q;
    assign overflow = ovf_q;
endmodule
